// File: rtl/copy_mem_to_packet.sv
// Replays packets stored in SRAM as a TX byte stream: regenerates preamble/SFD, streams the
// stored bytes verbatim, enforces the inter-frame gap and commits the SRAM read pointer.
module copy_mem_to_packet #(
  parameter int pDATA_WIDTH        = 8,
  parameter int pMAX_PACKET_LENGHT = 1536,
  parameter int pDEPTH_RAM         = 2 * pMAX_PACKET_LENGHT,
  parameter int pFIFO_WIDTH        = $clog2(pMAX_PACKET_LENGHT),
  parameter int pIFG_LEN           = 12
) (
  input  logic                          iclk,
  input  logic                          i_rst,
  input  logic                          iempty,
  input  logic [pFIFO_WIDTH-1:0]        ilen_pac,
  input  logic                          ipause,
  output logic                          olen_rd,
  output logic [$clog2(pDEPTH_RAM)-1:0] ordaddr,
  input  logic [pDATA_WIDTH-1:0]        irdata,
  output logic                          otx_en,
  output logic [pDATA_WIDTH-1:0]        otx_d,
  output logic [$clog2(pDEPTH_RAM)-1:0] optr_rd,
  output logic                          opkt_done,
  output logic                          oerr
);
  localparam int AW = $clog2(pDEPTH_RAM);
  localparam int CW = pFIFO_WIDTH + 1;
  localparam logic [pDATA_WIDTH-1:0] PREAMBLE_BYTE = pDATA_WIDTH'(8'h55);
  localparam logic [pDATA_WIDTH-1:0] SFD_BYTE      = pDATA_WIDTH'(8'hD5);
  localparam logic [CW-1:0]          PRE_LAST      = CW'(6);
  localparam logic [CW-1:0]          MAX_LEN       = CW'(pMAX_PACKET_LENGHT);
  // The IDLE look-ahead cycle also holds otx_en low, so the IFG state itself is one cycle shorter.
  localparam logic [CW-1:0]          IFG_LAST      = CW'(pIFG_LEN - 2);

  typedef enum logic [2:0] {S_IDLE, S_PREAMBLE, S_SFD, S_DATA, S_IFG} state_t;

  state_t                 state, state_d;
  logic [CW-1:0]          cnt, cnt_d;
  logic [pFIFO_WIDTH-1:0] len_q, len_d;
  logic [AW-1:0]          ptr_d, addr_d;
  logic                   len_rd_d, err_d, done_d, tx_en_d;
  logic [pDATA_WIDTH-1:0] tx_d_d;

  function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
    return (a == AW'(pDEPTH_RAM - 1)) ? '0 : a + AW'(1);
  endfunction

  // Lengths are always below pDEPTH_RAM, so one conditional subtraction is a full modulo.
  function automatic logic [AW-1:0] ptr_add(input logic [AW-1:0] p, input logic [pFIFO_WIDTH-1:0] l);
    logic [AW+1:0] s;
    s = {2'b00, p} + (AW+2)'(l);
    if (s >= (AW+2)'(pDEPTH_RAM)) s = s - (AW+2)'(pDEPTH_RAM);
    return s[AW-1:0];
  endfunction

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d  = state;
    cnt_d    = cnt;
    len_d    = len_q;
    ptr_d    = optr_rd;
    addr_d   = optr_rd;
    len_rd_d = 1'b0;
    err_d    = 1'b0;
    done_d   = 1'b0;
    tx_en_d  = 1'b0;
    tx_d_d   = '0;
    case (state)
      S_IDLE: begin
        // A pop issued last cycle has not reached the FIFO head yet; skip one look.
        if (!iempty && !ipause && !olen_rd) begin
          len_rd_d = 1'b1;
          len_d    = ilen_pac;
          cnt_d    = '0;
          if (ilen_pac == '0) begin
            state_d = S_IDLE;
          end else if ({1'b0, ilen_pac} > MAX_LEN) begin
            err_d = 1'b1;
            ptr_d = ptr_add(optr_rd, ilen_pac);
          end else begin
            state_d = S_PREAMBLE;
          end
        end
      end
      S_PREAMBLE: begin
        tx_en_d = 1'b1;
        tx_d_d  = PREAMBLE_BYTE;
        cnt_d   = cnt + CW'(1);
        if (cnt == PRE_LAST) begin
          cnt_d   = '0;
          state_d = S_SFD;
        end
      end
      S_SFD: begin
        tx_en_d = 1'b1;
        tx_d_d  = SFD_BYTE;
        addr_d  = addr_inc(optr_rd);
        cnt_d   = '0;
        state_d = S_DATA;
      end
      S_DATA: begin
        tx_en_d = 1'b1;
        tx_d_d  = irdata;
        addr_d  = addr_inc(ordaddr);
        cnt_d   = cnt + CW'(1);
        if (cnt == {1'b0, len_q} - CW'(1)) begin
          cnt_d   = '0;
          state_d = S_IFG;
        end
      end
      S_IFG: begin
        if (cnt == '0) begin
          done_d = 1'b1;
          ptr_d  = ptr_add(optr_rd, len_q);
        end
        cnt_d = cnt + CW'(1);
        if (cnt == IFG_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iclk) begin
    // NOTE: state and registered outputs update with non-blocking assignments only.
    if (i_rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      len_q     <= '0;
      optr_rd   <= '0;
      ordaddr   <= '0;
      olen_rd   <= 1'b0;
      oerr      <= 1'b0;
      opkt_done <= 1'b0;
      otx_en    <= 1'b0;
      otx_d     <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      len_q     <= len_d;
      optr_rd   <= ptr_d;
      ordaddr   <= addr_d;
      olen_rd   <= len_rd_d;
      oerr      <= err_d;
      opkt_done <= done_d;
      otx_en    <= tx_en_d;
      otx_d     <= tx_d_d;
    end
  end

endmodule

// File: tb/tb_copy_mem_to_packet.sv
// Bench for copy_mem_to_packet: length-FIFO and SRAM models, an event-level reference model
// feeding a scoreboard, and a forked monitor comparing every TX byte, done and error pulse.
module tb_copy_mem_to_packet;
  localparam int DW    = 8;
  localparam int MAXL  = 1536;
  localparam int DEPTH = 2 * MAXL;
  localparam int FW    = $clog2(MAXL);
  localparam int IFG   = 12;
  localparam int AW    = $clog2(DEPTH);

  typedef enum int {EV_BYTE, EV_DONE, EV_ERR} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       val;
  } ev_t;

  logic          iclk   = 1'b0;
  logic          i_rst  = 1'b1;
  logic          iempty = 1'b1;
  logic          ipause = 1'b0;
  logic [FW-1:0] ilen_pac = '0;
  logic [DW-1:0] irdata = '0;
  logic          olen_rd, otx_en, opkt_done, oerr;
  logic [AW-1:0] ordaddr, optr_rd;
  logic [DW-1:0] otx_d;

  logic [DW-1:0] mem [DEPTH];
  int            len_fifo[$];
  ev_t           exp_q[$];
  int            tests = 0;
  int            fails = 0;
  int            mptr = 0;
  int            pop_cnt = 0, txen_cnt = 0, done_cnt = 0, err_cnt = 0;
  int            low_run = 0, last_gap = -1;
  bit            prev_en = 1'b0, seen_rise = 1'b0;

  copy_mem_to_packet dut (
    .iclk      (iclk),
    .i_rst     (i_rst),
    .iempty    (iempty),
    .ilen_pac  (ilen_pac),
    .ipause    (ipause),
    .olen_rd   (olen_rd),
    .ordaddr   (ordaddr),
    .irdata    (irdata),
    .otx_en    (otx_en),
    .otx_d     (otx_d),
    .optr_rd   (optr_rd),
    .opkt_done (opkt_done),
    .oerr      (oerr)
  );

  always #5 iclk = ~iclk;

  // Synchronous-read SRAM: data for the address presented in one cycle appears in the next.
  always @(posedge iclk) irdata <= mem[ordaddr];

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic refresh_fifo();
    iempty   = (len_fifo.size() == 0);
    ilen_pac = iempty ? '0 : FW'(len_fifo[0]);
  endtask

  // Reference model: one queued length becomes the exact list of observable events.
  task automatic push_len(input int len);
    len_fifo.push_back(len);
    refresh_fifo();
    if (len > MAXL) begin
      mptr = (mptr + len) % DEPTH;
      exp_q.push_back('{kind: EV_ERR, val: mptr});
    end else if (len > 0) begin
      for (int i = 0; i < 7; i++) exp_q.push_back('{kind: EV_BYTE, val: 'h55});
      exp_q.push_back('{kind: EV_BYTE, val: 'hD5});
      for (int k = 0; k < len; k++) exp_q.push_back('{kind: EV_BYTE, val: int'(mem[(mptr + k) % DEPTH])});
      mptr = (mptr + len) % DEPTH;
      exp_q.push_back('{kind: EV_DONE, val: mptr});
    end
  endtask

  task automatic tick();
    @(negedge iclk);
    if (olen_rd) begin
      pop_cnt++;
      if (len_fifo.size() != 0) void'(len_fifo.pop_front());
      refresh_fifo();
    end
    if (opkt_done) done_cnt++;
    if (oerr) err_cnt++;
    if (otx_en) begin
      txen_cnt++;
      if (!prev_en && seen_rise) last_gap = low_run;
      seen_rise = 1'b1;
      low_run   = 0;
    end else begin
      low_run++;
    end
    prev_en = otx_en;
  endtask

  task automatic do_reset();
    i_rst  = 1'b1;
    ipause = 1'b0;
    tick();
    tick();
    len_fifo.delete();
    exp_q.delete();
    refresh_fifo();
    mptr      = 0;
    pop_cnt   = 0;
    txen_cnt  = 0;
    done_cnt  = 0;
    err_cnt   = 0;
    low_run   = 0;
    last_gap  = -1;
    seen_rise = 1'b0;
    i_rst     = 1'b0;
    tick();
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((len_fifo.size() != 0 || exp_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check({name, "_drained_in_budget"}, longint'(n < budget), 1);
    repeat (IFG + 4) tick();
  endtask

  task automatic monitor_step();
    ev_t      e;
    ev_kind_t k;
    if (!otx_en) check("tx_d_zero_when_idle", longint'(otx_d), 0);
    if (otx_en || opkt_done || oerr) begin
      k = otx_en ? EV_BYTE : (opkt_done ? EV_DONE : EV_ERR);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: got event %s, expected no event", k.name());
      end else begin
        e = exp_q.pop_front();
        check("event_kind", longint'(k), longint'(e.kind));
        if (k == EV_BYTE) check("tx_byte", longint'(otx_d), longint'(e.val));
        else if (k == EV_DONE) check("ptr_after_done", longint'(optr_rd), longint'(e.val));
        else check("ptr_after_err", longint'(optr_rd), longint'(e.val));
      end
    end
  endtask

  initial begin
    int n;
    fork
      forever begin
        @(negedge iclk);
        monitor_step();
      end
      begin
        #800000;
        $display("FAIL watchdog: time limit reached, expected run to finish");
        $fatal(1, "watchdog");
      end
    join_none

    for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
    for (int i = 0; i < 64; i++) mem[i] = DW'(i);

    // Reset state
    do_reset();
    check("rst_tx_en", longint'(otx_en), 0);
    check("rst_tx_d", longint'(otx_d), 0);
    check("rst_len_rd", longint'(olen_rd), 0);
    check("rst_done", longint'(opkt_done), 0);
    check("rst_err", longint'(oerr), 0);
    check("rst_ptr", longint'(optr_rd), 0);
    check("rst_addr", longint'(ordaddr), 0);

    // Single 64-byte packet from address 0
    push_len(64);
    wait_idle("single", 400);
    check("single_ptr", longint'(optr_rd), 64);
    check("single_pops", pop_cnt, 1);
    check("single_tx_cycles", txen_cnt, 72);
    check("single_done_pulses", done_cnt, 1);

    // Two queued packets: inter-frame gap and pointer accumulation
    do_reset();
    push_len(64);
    push_len(100);
    wait_idle("pair", 800);
    check("pair_gap", last_gap, IFG);
    check("pair_ptr", longint'(optr_rd), 164);
    check("pair_pops", pop_cnt, 2);
    check("pair_done_pulses", done_cnt, 2);

    // Pointer wrap at the end of SRAM
    do_reset();
    push_len(2047);
    push_len(1023);
    wait_idle("advance", 3000);
    check("advance_ptr", longint'(optr_rd), 3070);
    push_len(4);
    wait_idle("wrap", 200);
    check("wrap_ptr", longint'(optr_rd), 2);
    check("wrap_err_pulses", err_cnt, 1);
    check("wrap_done_pulses", done_cnt, 2);

    // Zero and oversize lengths are dropped
    do_reset();
    push_len(0);
    push_len(2000);
    push_len(64);
    wait_idle("discard", 600);
    check("discard_err_pulses", err_cnt, 1);
    check("discard_done_pulses", done_cnt, 1);
    check("discard_pops", pop_cnt, 3);
    check("discard_tx_cycles", txen_cnt, 72);
    check("discard_ptr", longint'(optr_rd), 2064);

    // Pause holds off a queued packet
    do_reset();
    ipause = 1'b1;
    push_len(10);
    repeat (50) tick();
    check("pause_pops", pop_cnt, 0);
    check("pause_tx_cycles", txen_cnt, 0);
    ipause = 1'b0;
    tick();
    check("release_pop_strobe", longint'(olen_rd), 1);
    check("release_tx_not_yet", longint'(otx_en), 0);
    tick();
    check("release_preamble_start", longint'(otx_en), 1);
    wait_idle("release", 200);

    // Reset in the middle of DATA byte 10
    do_reset();
    push_len(64);
    n = 0;
    while (txen_cnt < 19 && n < 200) begin
      tick();
      n++;
    end
    check("midrst_reached_byte10", txen_cnt, 19);
    i_rst = 1'b1;
    tick();
    check("midrst_tx_en", longint'(otx_en), 0);
    check("midrst_ptr", longint'(optr_rd), 0);
    check("midrst_addr", longint'(ordaddr), 0);
    do_reset();
    push_len(64);
    wait_idle("after_rst", 400);
    check("after_rst_ptr", longint'(optr_rd), 64);
    check("after_rst_tx_cycles", txen_cnt, 72);

    // Randomized lengths and pause activity
    do_reset();
    for (int p = 0; p < 25; p++) begin
      int r;
      int len;
      r = int'($urandom_range(0, 9));
      if (r == 0) len = 0;
      else if (r == 1) len = int'($urandom_range(MAXL + 1, (1 << FW) - 1));
      else len = int'($urandom_range(1, 120));
      push_len(len);
      repeat ($urandom_range(0, 80)) begin
        ipause = ($urandom_range(0, 3) == 0);
        tick();
      end
    end
    ipause = 1'b0;
    wait_idle("random", 20000);
    check("random_ptr", longint'(optr_rd), longint'(mptr));
    check("random_pops", pop_cnt, 25);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
